// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - shared encodings for the multicycle controller and datapath
package mc_controller_pkg;

  // 15 controller states; the 16th encoding is unused and recovers to fetch1
  typedef enum logic [3:0] {
    s_fetch1  = 4'd0,
    s_fetch2  = 4'd1,
    s_fetch3  = 4'd2,
    s_fetch4  = 4'd3,
    s_decode  = 4'd4,
    s_memadr  = 4'd5,
    s_lbrd    = 4'd6,
    s_lbwr    = 4'd7,
    s_sbwr    = 4'd8,
    s_rtypeex = 4'd9,
    s_rtypewr = 4'd10,
    s_beqex   = 4'd11,
    s_jex     = 4'd12,
    s_addiex  = 4'd13,
    s_addiwr  = 4'd14
  } state_t;

  // opcodes, instr[31:26]
  localparam logic [5:0] op_lb    = 6'b100000;
  localparam logic [5:0] op_sb    = 6'b101000;
  localparam logic [5:0] op_rtype = 6'b000000;
  localparam logic [5:0] op_beq   = 6'b000100;
  localparam logic [5:0] op_j     = 6'b000010;
  localparam logic [5:0] op_addi  = 6'b001000;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] funct_add = 6'b100000;
  localparam logic [5:0] funct_sub = 6'b100010;
  localparam logic [5:0] funct_and = 6'b100100;
  localparam logic [5:0] funct_or  = 6'b100101;
  localparam logic [5:0] funct_slt = 6'b101010;

  // ALU operation codes seen by the datapath ALU
  localparam logic [2:0] alu_and = 3'b000;
  localparam logic [2:0] alu_or  = 3'b001;
  localparam logic [2:0] alu_add = 3'b010;
  localparam logic [2:0] alu_sub = 3'b110;
  localparam logic [2:0] alu_slt = 3'b111;

  // aluop: what the FSM asks of the ALU decoder
  localparam logic [1:0] aluop_add   = 2'b00;
  localparam logic [1:0] aluop_sub   = 2'b01;
  localparam logic [1:0] aluop_funct = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - controller/datapath signal bundle
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       memtoreg;
  logic       regdst;
  logic       iord;
  logic       regwrite;
  logic [3:0] irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  // controller side: consumes instruction fields and flags, drives controls
  modport master (
    input  op, funct, zero,
    output memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord,
           regwrite, irwrite, pcen, pcsrc, alucontrol
  );

  // datapath side
  modport slave (
    output op, funct, zero,
    input  memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord,
           regwrite, irwrite, pcen, pcsrc, alucontrol
  );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// rtl/mc_controller_alu_decoder.sv - aluop/funct to ALU operation code
module alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // add/sub are forced by the FSM; R-type defers to funct, unknown codes add
  always_comb begin
    alucontrol = alu_add;
    case (aluop)
      aluop_add: alucontrol = alu_add;
      aluop_sub: alucontrol = alu_sub;
      aluop_funct: begin
        case (funct)
          funct_add: alucontrol = alu_add;
          funct_sub: alucontrol = alu_sub;
          funct_and: alucontrol = alu_and;
          funct_or:  alucontrol = alu_or;
          funct_slt: alucontrol = alu_slt;
          default:   alucontrol = alu_add;
        endcase
      end
      default: alucontrol = alu_add;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle byte-fetch controller FSM
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_controller_if.master bus
);

  state_t     state, next_state;
  logic       memread_c, memwrite_c, alusrca_c, memtoreg_c, regdst_c, iord_c, regwrite_c;
  logic [1:0] alusrcb_c, pcsrc_c, aluop;
  logic [3:0] irwrite_c;
  logic       pcwrite, branch;

  // state register; reset drops straight back to fetch1 even mid-instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= s_fetch1;
    else       state <= next_state;
  end

  // next-state and Moore control decode; anything not set below stays 0
  always_comb begin
    next_state = s_fetch1;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    memtoreg_c = 1'b0;
    regdst_c   = 1'b0;
    iord_c     = 1'b0;
    regwrite_c = 1'b0;
    irwrite_c  = 4'b0000;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc_c    = 2'b00;
    aluop      = aluop_add;
    case (state)
      // each fetch state loads one instruction byte and bumps PC by one
      s_fetch1: begin
        memread_c = 1'b1; irwrite_c = 4'b0001; alusrcb_c = 2'b01; pcwrite = 1'b1;
        next_state = s_fetch2;
      end
      s_fetch2: begin
        memread_c = 1'b1; irwrite_c = 4'b0010; alusrcb_c = 2'b01; pcwrite = 1'b1;
        next_state = s_fetch3;
      end
      s_fetch3: begin
        memread_c = 1'b1; irwrite_c = 4'b0100; alusrcb_c = 2'b01; pcwrite = 1'b1;
        next_state = s_fetch4;
      end
      s_fetch4: begin
        memread_c = 1'b1; irwrite_c = 4'b1000; alusrcb_c = 2'b01; pcwrite = 1'b1;
        next_state = s_decode;
      end
      // decode precomputes the branch target while dispatching on op
      s_decode: begin
        alusrcb_c = 2'b11;
        case (bus.op)
          op_lb, op_sb: next_state = s_memadr;
          op_rtype:     next_state = s_rtypeex;
          op_beq:       next_state = s_beqex;
          op_j:         next_state = s_jex;
          op_addi:      next_state = s_addiex;
          default:      next_state = s_fetch1;
        endcase
      end
      s_memadr: begin
        alusrca_c = 1'b1; alusrcb_c = 2'b10;
        if (bus.op == op_lb)      next_state = s_lbrd;
        else if (bus.op == op_sb) next_state = s_sbwr;
        else                      next_state = s_fetch1;
      end
      s_lbrd: begin
        memread_c = 1'b1; iord_c = 1'b1;
        next_state = s_lbwr;
      end
      s_lbwr: begin
        regwrite_c = 1'b1; memtoreg_c = 1'b1;
      end
      s_sbwr: begin
        memwrite_c = 1'b1; iord_c = 1'b1;
      end
      s_rtypeex: begin
        alusrca_c = 1'b1; aluop = aluop_funct;
        next_state = s_rtypewr;
      end
      s_rtypewr: begin
        regwrite_c = 1'b1; regdst_c = 1'b1;
      end
      s_beqex: begin
        alusrca_c = 1'b1; aluop = aluop_sub; branch = 1'b1; pcsrc_c = 2'b01;
      end
      s_jex: begin
        pcwrite = 1'b1; pcsrc_c = 2'b10;
      end
      s_addiex: begin
        alusrca_c = 1'b1; alusrcb_c = 2'b10;
        next_state = s_addiwr;
      end
      s_addiwr: begin
        regwrite_c = 1'b1;
      end
      default: next_state = s_fetch1;
    endcase
  end

  // strobes are masked while reset is high; mux selects already show fetch1
  assign bus.memread  = memread_c & ~reset;
  assign bus.memwrite = memwrite_c & ~reset;
  assign bus.regwrite = regwrite_c & ~reset;
  assign bus.irwrite  = reset ? 4'b0000 : irwrite_c;
  assign bus.pcen     = ~reset & (pcwrite | (branch & bus.zero));
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.memtoreg = memtoreg_c;
  assign bus.regdst   = regdst_c;
  assign bus.iord     = iord_c;
  assign bus.pcsrc    = pcsrc_c;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
module tb_mc_controller;

  localparam logic [5:0] t_lb = 6'b100000, t_sb = 6'b101000, t_rt = 6'b000000;
  localparam logic [5:0] t_beq = 6'b000100, t_j = 6'b000010, t_addi = 6'b001000;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       regwrite;
    logic [3:0] irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctl_t;

  typedef struct {
    ctl_t v;
    int   instr;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   active = 1'b0;
  exp_t exp_q[$];

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t sample();
    return {bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb, bus.memtoreg,
            bus.regdst, bus.iord, bus.regwrite, bus.irwrite, bus.pcen, bus.pcsrc,
            bus.alucontrol};
  endfunction

  function automatic ctl_t base();
    ctl_t v;
    v = '0;
    v.alucontrol = 3'b010;
    return v;
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic push(input ctl_t v, input int id, input int cyc);
    exp_t e;
    e.v = v; e.instr = id; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // reference: the per-cycle control vectors one instruction should produce
  task automatic model(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int id, output int n);
    ctl_t v;
    int   c;
    c = 0;
    for (int k = 0; k < 4; k++) begin
      v = base(); v.memread = 1; v.irwrite = 4'(1 << k); v.alusrcb = 2'b01; v.pcen = 1;
      push(v, id, c); c++;
    end
    v = base(); v.alusrcb = 2'b11; push(v, id, c); c++;
    if (o == t_lb || o == t_sb) begin
      v = base(); v.alusrca = 1; v.alusrcb = 2'b10; push(v, id, c); c++;
      if (o == t_lb) begin
        v = base(); v.memread = 1; v.iord = 1; push(v, id, c); c++;
        v = base(); v.regwrite = 1; v.memtoreg = 1; push(v, id, c); c++;
      end else begin
        v = base(); v.memwrite = 1; v.iord = 1; push(v, id, c); c++;
      end
    end else if (o == t_rt) begin
      v = base(); v.alusrca = 1; v.alucontrol = rtype_alu(f); push(v, id, c); c++;
      v = base(); v.regwrite = 1; v.regdst = 1; push(v, id, c); c++;
    end else if (o == t_beq) begin
      v = base(); v.alusrca = 1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.pcen = z;
      push(v, id, c); c++;
    end else if (o == t_j) begin
      v = base(); v.pcen = 1; v.pcsrc = 2'b10; push(v, id, c); c++;
    end else if (o == t_addi) begin
      v = base(); v.alusrca = 1; v.alusrcb = 2'b10; push(v, id, c); c++;
      v = base(); v.regwrite = 1; push(v, id, c); c++;
    end
    n = c;
  endtask

  // called just after a rising edge; leaves just after the instruction's last edge
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int id);
    int n;
    bus.op = o; bus.funct = f; bus.zero = z;
    model(o, f, z, id, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_direct(input string name, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  // monitor: every non-reset cycle pops one expected vector and compares
  always @(negedge clk) begin
    exp_t e;
    ctl_t act;
    if (active && !reset) begin
      act = sample();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underrun: got %05h with nothing expected", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.v) begin
          errors++;
          $display("FAIL instr%0d cycle%0d op=%06b funct=%06b zero=%0b: got %05h expected %05h",
                   e.instr, e.cyc + 1, bus.op, bus.funct, bus.zero, act, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t rst_v;
    logic [5:0] o, f;
    int id;
    int r;
    rst_v = base(); rst_v.alusrcb = 2'b01;
    bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_direct("reset_state", sample(), rst_v);
    bus.zero = 1'b1;
    #1;
    check_direct("reset_pcen_zero1", sample(), rst_v);

    reset = 1'b0;
    active = 1'b1;
    id = 0;
    run_instr(t_rt,   6'b100010, 1'b0, id++);
    run_instr(t_beq,  6'b000000, 1'b1, id++);
    run_instr(t_beq,  6'b000000, 1'b0, id++);
    run_instr(t_lb,   6'b000000, 1'b0, id++);
    run_instr(t_sb,   6'b000000, 1'b1, id++);
    run_instr(6'b111111, 6'b100000, 1'b0, id++);
    run_instr(t_addi, 6'b000000, 1'b1, id++);
    run_instr(t_j,    6'b000000, 1'b0, id++);
    run_instr(t_rt,   6'b100100, 1'b0, id++);
    run_instr(t_rt,   6'b100101, 1'b1, id++);
    run_instr(t_rt,   6'b101010, 1'b0, id++);
    run_instr(t_rt,   6'b111000, 1'b0, id++);

    // reset asserted asynchronously while the load is in its read cycle
    bus.op = t_lb; bus.funct = 6'($urandom); bus.zero = 1'b0;
    begin
      int n;
      model(t_lb, bus.funct, 1'b0, id++, n);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    active = 1'b0;
    checks++;
    if (exp_q.size() != 1) begin
      errors++;
      $display("FAIL mid_lbrd_queue: %0d entries left, expected 1", exp_q.size());
    end
    exp_q.delete();
    #1;
    check_direct("reset_mid_lbrd", sample(), rst_v);
    @(posedge clk);
    #1;
    check_direct("reset_held", sample(), rst_v);
    reset = 1'b0;
    active = 1'b1;
    run_instr(t_sb, 6'b000000, 1'b0, id++);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: o = t_lb;
        1: o = t_sb;
        2: o = t_rt;
        3: o = t_beq;
        4: o = t_j;
        5: o = t_addi;
        default: begin
          o = 6'($urandom);
          while (o == t_lb || o == t_sb || o == t_rt || o == t_beq || o == t_j || o == t_addi)
            o = 6'($urandom);
        end
      endcase
      case ($urandom_range(0, 5))
        0: f = 6'b100000;
        1: f = 6'b100010;
        2: f = 6'b100100;
        3: f = 6'b100101;
        4: f = 6'b101010;
        default: f = 6'($urandom);
      endcase
      run_instr(o, f, 1'($urandom_range(0, 1)), id++);
    end

    active = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected vectors never observed", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all encodings are fixed constants from the shared package.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instr[31:26] from the datapath instruction register.
REQ-005 funct  input  6  instr[5:0] from the datapath instruction register.
REQ-006 zero  input  1  datapath ALU zero flag.
REQ-007 memread  output  1  memory read strobe.
REQ-008 memwrite  output  1  memory write strobe.
REQ-009 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-010 alusrcb  output  2  ALU B select: 00 = B, 01 = const 1, 10 = imm, 11 = imm (branch offset).
REQ-011 memtoreg, regdst, iord  output  1 each  datapath mux selects.
REQ-012 regwrite  output  1  register file write enable.
REQ-013 irwrite  output  4  one-hot byte enable for the instruction register.
REQ-014 pcen  output  1  PC write enable.
REQ-015 pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALU out register, 10 = jump target.
REQ-016 alucontrol  output  3  ALU operation code.

Function
REQ-017 Moore FSM; the 4-bit state register updates on the rising edge of clk; outputs are combinational from state, except pcen and alucontrol.
REQ-018 States: FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR.
REQ-019 FETCHn (n = 1..4): memread = 1, irwrite = 1 << (n-1), alusrca = 0, alusrcb = 01, pcsrc = 00, pcwrite = 1; FETCHn -> FETCHn+1, FETCH4 -> DECODE.
REQ-020 DECODE: alusrca = 0, alusrcb = 11, aluop = 00.
REQ-021 DECODE branches on op: LB 100000 or SB 101000 -> MEMADR; RTYPE 000000 -> RTYPEEX; BEQ 000100 -> BEQEX; J 000010 -> JEX; ADDI 001000 -> ADDIEX; any other op -> FETCH1.
REQ-022 MEMADR and ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00; MEMADR -> LBRD on LB, -> SBWR on SB; ADDIEX -> ADDIWR.
REQ-023 LBRD: memread = 1, iord = 1, -> LBWR; LBWR: regwrite = 1, memtoreg = 1, regdst = 0, -> FETCH1.
REQ-024 SBWR: memwrite = 1, iord = 1, -> FETCH1.
REQ-025 RTYPEEX: alusrca = 1, alusrcb = 00, aluop = 10, -> RTYPEWR; RTYPEWR: regwrite = 1, regdst = 1, memtoreg = 0, -> FETCH1.
REQ-026 ADDIWR: regwrite = 1, regdst = 0, memtoreg = 0, -> FETCH1.
REQ-027 BEQEX: alusrca = 1, alusrcb = 00, aluop = 01, branch = 1, pcsrc = 01, -> FETCH1.
REQ-028 JEX: pcwrite = 1, pcsrc = 10, -> FETCH1.
REQ-029 pcen = pcwrite OR (branch AND zero), combinational within the current cycle.
REQ-030 alucontrol decode: aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
REQ-031 alucontrol decode, aluop 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
REQ-032 Any signal not listed for a state is 0.
REQ-033 Instruction latency: LB = 8 cycles, SB/RTYPE/ADDI = 7 cycles, BEQ/J = 6 cycles.

Reset
REQ-034 Asserting reset forces the state to FETCH1 immediately, including mid-instruction.
REQ-035 While reset is high: memwrite, regwrite, pcen and irwrite = 0; memread = 0; other outputs carry FETCH1 values.
REQ-036 The first clock edge after reset deasserts executes FETCH1 (irwrite = 0001).

Structure
REQ-037 The shared package holds the state encodings, the six opcode constants, the funct constants and the 3-bit ALU codes; the datapath uses the same package.
REQ-038 The alucontrol decode is a separate combinational sub-module, alu_decoder (aluop[1:0], funct[5:0] -> alucontrol[2:0]).

Verification
REQ-039 Reset pulse mid-LBRD -> state becomes FETCH1 asynchronously; no write strobe is asserted during reset.
REQ-040 op = 000000, funct = 100010 -> irwrite sequence 0001/0010/0100/1000; RTYPEEX drives alucontrol = 110; RTYPEWR drives regwrite = 1, regdst = 1.
REQ-041 op = 000100, zero = 1 in BEQEX -> pcen = 1, pcsrc = 01, alucontrol = 110; same with zero = 0 -> pcen = 0.
REQ-042 op = 100000 -> states MEMADR, LBRD (iord = 1, memread = 1), LBWR (memtoreg = 1, regwrite = 1); next instruction starts at cycle 9.
REQ-043 op = 101000 -> SBWR drives memwrite = 1, iord = 1; regwrite stays 0 throughout.
REQ-044 op = 111111 -> DECODE -> FETCH1; no regwrite or memwrite is asserted.
